// File: rtl/cnn_cell_iter.sv
// -----------------------------------------------------------------------------
// cnn_cell_iter
//   Self-iterating CNN cell. One shared multiplier Euler-integrates
//     X' = -X + sum(A*Y) + sum(B*U) + I
//   over a 3x3 neighbourhood. The output is Y = clamp(X, -ONE, +ONE). The cell
//   iterates until ITER_MAX steps or, optionally, until the state converges.
//   The feed-forward term sum(B*U) + I is computed once per run. The feedback
//   term sum(A*Y) is recomputed every iteration from a snapshot of Y_nb.
//
// Optional feature macro: CNN_CONV_DETECT_EN
//   Defined   : a run also ends when |X_next - X| <= TOL.
//   Undefined : every run lasts exactly ITER_MAX iterations and TOL is ignored.
//
// Ports
//   clk, rst      rising-edge clock; synchronous active-high reset
//   start         begin a run (sampled only while idle)
//   A_flat/B_flat feedback/control templates, tap k at [k*WIDTH +: WIDTH]
//   U_flat        input neighbourhood, same layout
//   I             bias
//   X0            initial state (2*WIDTH)
//   Y_nb          neighbour outputs, tap k at [k*2*WIDTH +: 2*WIDTH]
//   Xout, Yout    current state and its clamped output
//   busy          run in progress
//   step_done     one-cycle pulse per completed iteration
//   iter_cnt      completed iterations in this run
//   fin_flag      run finished (held until next start)
//   counter_flag  run ended on the iteration limit
// -----------------------------------------------------------------------------
module cnn_cell_iter #(
    parameter int WIDTH    = 9,
    parameter int FRAC     = 4,
    parameter int DT_SHIFT = 0,
    parameter int ITER_MAX = 64,
    parameter int TOL      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [9*WIDTH-1:0]     A_flat,
    input  logic [9*WIDTH-1:0]     B_flat,
    input  logic [9*WIDTH-1:0]     U_flat,
    input  logic [WIDTH-1:0]       I,
    input  logic [2*WIDTH-1:0]     X0,
    input  logic [18*WIDTH-1:0]    Y_nb,
    output logic [2*WIDTH-1:0]     Xout,
    output logic [2*WIDTH-1:0]     Yout,
    output logic                   busy,
    output logic                   step_done,
    output logic [7:0]             iter_cnt,
    output logic                   fin_flag,
    output logic                   counter_flag
);

    localparam int XW    = 2 * WIDTH;
    localparam int XW1   = XW + 1;
    localparam int PW    = 3 * WIDTH;
    localparam int ACC_W = 3 * WIDTH + FRAC + 4;

    localparam logic signed [ACC_W-1:0] X_MAX  = {{(ACC_W-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] X_MIN  = {{(ACC_W-XW+1){1'b1}}, {(XW-1){1'b0}}};
    localparam logic signed [XW-1:0]    ONE_X  = XW'(2 ** FRAC);
    localparam logic signed [XW-1:0]    NEG_ONE = -ONE_X;
    localparam logic [8:0]              ITER_LIM = 9'(ITER_MAX);
    localparam logic [XW:0]             TOL_V  = XW1'(TOL);

`ifdef CNN_CONV_DETECT_EN
    localparam bit CONV_EN = 1'b1;
`else
    // The comparator below is constant-folded away in this build.
    localparam bit CONV_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_BU, S_LDY, S_AY, S_UPD, S_DONE} state_t;

    function automatic logic signed [XW-1:0] sat_x(input logic signed [ACC_W-1:0] v);
        if (v > X_MAX)      return X_MAX[XW-1:0];
        else if (v < X_MIN) return X_MIN[XW-1:0];
        else                return v[XW-1:0];
    endfunction

    function automatic logic signed [XW-1:0] clamp_y(input logic signed [XW-1:0] v);
        if (v > ONE_X)        return ONE_X;
        else if (v < NEG_ONE) return NEG_ONE;
        else                  return v;
    endfunction

    state_t                   state;
    logic [3:0]               tap;
    logic signed [WIDTH-1:0]  a_q [9];
    logic signed [WIDTH-1:0]  b_q [9];
    logic signed [WIDTH-1:0]  u_q [9];
    logic signed [WIDTH-1:0]  i_q;
    logic signed [XW-1:0]     y_snap [9];
    logic signed [ACC_W-1:0]  acc_bu;
    logic signed [ACC_W-1:0]  acc;
    logic signed [XW-1:0]     x_q;
    logic signed [XW-1:0]     y_q;

    // Shared multiplier and update datapath.
    logic signed [WIDTH-1:0]  mul_a;
    logic signed [XW-1:0]     mul_b;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  bu_bias;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [XW-1:0]     s_val;
    logic signed [XW:0]       diff;
    logic signed [XW:0]       delta;
    logic signed [ACC_W-1:0]  x_sum;
    logic signed [XW-1:0]     x_next;
    logic signed [XW:0]       step;
    logic [XW:0]              step_abs;
    logic                     converged;
    logic                     at_limit;
    logic [7:0]               iter_inc;

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        mul_a = a_q[tap];
        mul_b = y_snap[tap];
        if (state == S_BU) begin
            mul_a = b_q[tap];
            mul_b = XW'(u_q[tap]);
        end
        prod    = PW'(mul_a) * PW'(mul_b);
        bu_bias = (tap == 4'd8) ? (ACC_W'(i_q) <<< FRAC) : '0;

        acc_sh   = acc >>> FRAC;
        s_val    = sat_x(acc_sh);
        diff     = XW1'(s_val) - XW1'(x_q);
        delta    = diff >>> DT_SHIFT;
        x_sum    = ACC_W'(x_q) + ACC_W'(delta);
        x_next   = sat_x(x_sum);
        step     = XW1'(x_next) - XW1'(x_q);
        step_abs = step[XW] ? $unsigned(-step) : $unsigned(step);
        converged = CONV_EN && (step_abs <= TOL_V);

        at_limit = ({1'b0, iter_cnt} + 9'd1) == ITER_LIM;
        iter_inc = (iter_cnt == 8'hFF) ? iter_cnt : iter_cnt + 8'd1;
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tap          <= '0;
            // NOTE: the small operand/snapshot arrays are plain flops and are reset, keeping outputs deterministic.
            for (int k = 0; k < 9; k++) begin
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                u_q[k]    <= '0;
                y_snap[k] <= '0;
            end
            i_q          <= '0;
            acc_bu       <= '0;
            acc          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            busy         <= 1'b0;
            step_done    <= 1'b0;
            iter_cnt     <= '0;
            fin_flag     <= 1'b0;
            counter_flag <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 9; k++) begin
                            a_q[k] <= A_flat[k*WIDTH +: WIDTH];
                            b_q[k] <= B_flat[k*WIDTH +: WIDTH];
                            u_q[k] <= U_flat[k*WIDTH +: WIDTH];
                        end
                        i_q          <= I;
                        x_q          <= X0;
                        y_q          <= clamp_y($signed(X0));
                        iter_cnt     <= '0;
                        fin_flag     <= 1'b0;
                        counter_flag <= 1'b0;
                        acc_bu       <= '0;
                        tap          <= '0;
                        busy         <= 1'b1;
                        state        <= S_BU;
                    end
                end
                S_BU: begin
                    // Bias joins on the last tap so acc_bu is final when BU ends.
                    acc_bu <= acc_bu + ACC_W'(prod) + bu_bias;
                    if (tap == 4'd8) begin
                        tap   <= '0;
                        state <= S_LDY;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                S_LDY: begin
                    for (int k = 0; k < 9; k++)
                        y_snap[k] <= Y_nb[k*XW +: XW];
                    acc   <= acc_bu;
                    tap   <= '0;
                    state <= S_AY;
                end
                S_AY: begin
                    acc <= acc + ACC_W'(prod);
                    if (tap == 4'd8) begin
                        tap   <= '0;
                        state <= S_UPD;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                S_UPD: begin
                    x_q       <= x_next;
                    y_q       <= clamp_y(x_next);
                    iter_cnt  <= iter_inc;
                    step_done <= 1'b1;
                    if (at_limit) begin
                        counter_flag <= 1'b1;
                        state        <= S_DONE;
                    end else if (converged) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_LDY;
                    end
                end
                S_DONE: begin
                    fin_flag <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Xout = x_q;
    assign Yout = y_q;

endmodule

// File: tb/tb_cnn_cell_iter.sv
// -----------------------------------------------------------------------------
// tb_cnn_cell_iter
//   Two cells are instantiated. dut0 uses DT_SHIFT=0 and ITER_MAX=4. dut1 uses
//   DT_SHIFT=1 and ITER_MAX=64. A reference model predicts every iteration of a
//   run and queues the expected results. A monitor pops and compares them on
//   each step_done. Y_nb holds the real neighbour values only during the
//   snapshot cycle of each iteration and carries noise at all other times.
//   Operands are scrambled after start to show they were latched.
// -----------------------------------------------------------------------------
module tb_cnn_cell_iter;

    localparam int W  = 9;
    localparam int XW = 18;

`ifdef CNN_CONV_DETECT_EN
    localparam bit CONV = 1'b1;
`else
    localparam bit CONV = 1'b0;
`endif

    typedef struct {
        longint x;
        longint y;
        int     it;
        longint cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start [2];
    logic [9*W-1:0]   A_flat, B_flat, U_flat;
    logic [W-1:0]     I;
    logic [XW-1:0]    X0;
    logic [9*XW-1:0]  Y_nb;
    logic [XW-1:0]    xout [2];
    logic [XW-1:0]    yout [2];
    logic             busy [2];
    logic             step_done [2];
    logic [7:0]       iter_cnt [2];
    logic             fin_flag [2];
    logic             counter_flag [2];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   mon_e;
    logic signed [63:0] first_x [2];
    logic signed [63:0] first_y [2];

    int     stim_a[9], stim_b[9], stim_u[9];
    int     stim_i, stim_x0;
    int     stim_y[64][9];
    bit     run_active = 1'b0;
    longint run_start = 0;
    longint yd_rel;
    int     yd_j;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_cell_iter #(.WIDTH(W), .FRAC(4), .DT_SHIFT(0), .ITER_MAX(4), .TOL(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .A_flat(A_flat), .B_flat(B_flat), .U_flat(U_flat), .I(I), .X0(X0), .Y_nb(Y_nb),
        .Xout(xout[0]), .Yout(yout[0]), .busy(busy[0]), .step_done(step_done[0]),
        .iter_cnt(iter_cnt[0]), .fin_flag(fin_flag[0]), .counter_flag(counter_flag[0])
    );

    cnn_cell_iter #(.WIDTH(W), .FRAC(4), .DT_SHIFT(1), .ITER_MAX(64), .TOL(0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .A_flat(A_flat), .B_flat(B_flat), .U_flat(U_flat), .I(I), .X0(X0), .Y_nb(Y_nb),
        .Xout(xout[1]), .Yout(yout[1]), .busy(busy[1]), .step_done(step_done[1]),
        .iter_cnt(iter_cnt[1]), .fin_flag(fin_flag[1]), .counter_flag(counter_flag[1])
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat_m(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic longint clamp_m(input longint v);
        if (v > 16)  return 16;
        if (v < -16) return -16;
        return v;
    endfunction

    function automatic logic signed [63:0] sx(input logic [XW-1:0] v);
        return 64'($signed(v));
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(32'(hi - lo)));
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Y_nb: real values only in each iteration's snapshot cycle (10 + 11*j after start).
    always @(negedge clk) begin
        yd_rel = cyc - run_start;
        if (run_active && yd_rel >= 10 && ((yd_rel - 10) % 11) == 0 && ((yd_rel - 10) / 11) < 64) begin
            yd_j = int'((yd_rel - 10) / 11);
            for (int k = 0; k < 9; k++) Y_nb[k*XW +: XW] = XW'(stim_y[yd_j][k]);
        end else begin
            for (int k = 0; k < 9; k++) Y_nb[k*XW +: XW] = XW'($urandom);
        end
    end

    // Monitor: compare each completed iteration against the queued prediction.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (step_done[d]) begin
                if (qsize(d) == 0) begin
                    check("unexpected_step_done", 1, 0);
                end else begin
                    if (d == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    check("step_x", sx(xout[d]), mon_e.x);
                    check("step_y", sx(yout[d]), mon_e.y);
                    check("step_iter", 64'(iter_cnt[d]), 64'(mon_e.it));
                    check("step_cycle", cyc, mon_e.cyc);
                    if (mon_e.it == 1) begin
                        first_x[d] = sx(xout[d]);
                        first_y[d] = sx(yout[d]);
                    end
                end
            end
        end
    end

    task automatic clear_stim();
        for (int k = 0; k < 9; k++) begin
            stim_a[k] = 0; stim_b[k] = 0; stim_u[k] = 0;
        end
        stim_i = 0; stim_x0 = 0;
        for (int j = 0; j < 64; j++)
            for (int k = 0; k < 9; k++) stim_y[j][k] = 0;
    endtask

    task automatic scramble();
        for (int k = 0; k < 9; k++) begin
            A_flat[k*W +: W] = W'($urandom);
            B_flat[k*W +: W] = W'($urandom);
            U_flat[k*W +: W] = W'($urandom);
        end
        I  = W'($urandom);
        X0 = XW'($urandom);
    endtask

    task automatic fill_random(input int mode);
        int ya;
        int am;
        ya = (mode == 0) ? 16 : 131071;
        am = (mode == 0) ? 64 : 255;
        for (int k = 0; k < 9; k++) begin
            stim_a[k] = rnd(-am, am);
            stim_b[k] = rnd(-255, 255);
            stim_u[k] = rnd(-255, 255);
        end
        stim_i  = rnd(-255, 255);
        stim_x0 = (mode == 0) ? rnd(-64, 64) : rnd(-131072, 131071);
        for (int j = 0; j < 64; j++)
            for (int k = 0; k < 9; k++) stim_y[j][k] = rnd(-ya - 1, ya);
    endtask

    task automatic run_cell(input int d);
        longint bu, acc, s, x, xn, dx, s_cyc;
        int     itmax, dt, n;
        bit     lim, conv, seen;
        exp_t   e;
        itmax = (d == 0) ? 4 : 64;
        dt    = (d == 0) ? 0 : 1;

        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            A_flat[k*W +: W] = W'(stim_a[k]);
            B_flat[k*W +: W] = W'(stim_b[k]);
            U_flat[k*W +: W] = W'(stim_u[k]);
        end
        I  = W'(stim_i);
        X0 = XW'(stim_x0);
        s_cyc = cyc;

        // Reference: Euler steps of X' = -X + A*Y + B*U + I in fixed point.
        bu = longint'(stim_i) * 16;
        for (int k = 0; k < 9; k++) bu += longint'(stim_b[k]) * stim_u[k];
        x = stim_x0; n = 0; lim = 0; conv = 0;
        for (int j = 0; j < itmax; j++) begin
            acc = bu;
            for (int k = 0; k < 9; k++) acc += longint'(stim_a[k]) * stim_y[j][k];
            s  = sat_m(acc >>> 4);
            xn = sat_m(x + ((s - x) >>> dt));
            e.x = xn; e.y = clamp_m(xn); e.it = j + 1; e.cyc = s_cyc + 21 + 11 * j;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            dx   = (xn > x) ? xn - x : x - xn;
            lim  = (j + 1 == itmax);
            conv = CONV && (dx <= 0);
            x = xn;
            n = j + 1;
            if (lim || conv) break;
        end

        run_start  = s_cyc;
        run_active = 1'b1;
        start[d]   = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        scramble();
        check("busy_after_start", 64'(busy[d]), 1);
        check("fin_cleared", 64'(fin_flag[d]), 0);
        check("cflag_cleared", 64'(counter_flag[d]), 0);
        check("iter_cleared", 64'(iter_cnt[d]), 0);
        check("x0_loaded", sx(xout[d]), stim_x0);
        check("y0_loaded", sx(yout[d]), clamp_m(stim_x0));

        // Start pulse during BU must be ignored.
        repeat (4) @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;

        seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (fin_flag[d]) begin
                seen = 1'b1;
                break;
            end
        end
        check("fin_reached", 64'(seen), 1);
        if (seen) begin
            check("fin_cycle", cyc, s_cyc + 22 + 11 * longint'(n - 1));
            check("busy_low_at_fin", 64'(busy[d]), 0);
            check("counter_flag", 64'(counter_flag[d]), 64'(lim));
            check("iter_final", 64'(iter_cnt[d]), 64'(n));
            check("x_final", sx(xout[d]), x);
            check("queue_drained", 64'(qsize(d)), 0);
        end
        if (d == 0) q0.delete();
        else        q1.delete();
        run_active = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        A_flat = '0; B_flat = '0; U_flat = '0; I = '0; X0 = '0;
        first_x[0] = 0; first_x[1] = 0; first_y[0] = 0; first_y[1] = 0;
        clear_stim();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 64'(busy[d]), 0);
            check("rst_step_done", 64'(step_done[d]), 0);
            check("rst_x", sx(xout[d]), 0);
            check("rst_y", sx(yout[d]), 0);
            check("rst_iter", 64'(iter_cnt[d]), 0);
            check("rst_fin", 64'(fin_flag[d]), 0);
            check("rst_cflag", 64'(counter_flag[d]), 0);
        end
        rst = 1'b0;

        // Bias only: X steps straight to I.
        clear_stim();
        stim_i = 16;
        run_cell(0);
        check("t1_x", sx(xout[0]), 16);
        check("t1_y", sx(yout[0]), 16);
`ifdef CNN_CONV_DETECT_EN
        check("t1_iter", 64'(iter_cnt[0]), 2);
        check("t1_cflag", 64'(counter_flag[0]), 0);
`else
        check("t1_iter", 64'(iter_cnt[0]), 4);
        check("t1_cflag", 64'(counter_flag[0]), 1);
`endif

        // Control term only: output clamps while state does not.
        clear_stim();
        stim_b[4] = 32;
        stim_u[4] = 16;
        run_cell(0);
        check("t2_x", sx(xout[0]), 32);
        check("t2_y", sx(yout[0]), 16);

        // Feedback with half step.
        clear_stim();
        stim_a[4] = 16;
        for (int j = 0; j < 64; j++) stim_y[j][4] = -16;
        run_cell(1);
        check("t3_first_x", first_x[1], -8);
        check("t3_first_y", first_y[1], -8);

        // Saturation in both directions.
        clear_stim();
        for (int k = 0; k < 9; k++) stim_a[k] = 255;
        for (int j = 0; j < 64; j++)
            for (int k = 0; k < 9; k++) stim_y[j][k] = 131071;
        run_cell(0);
        check("t4_pos_x", sx(xout[0]), 131071);
        check("t4_pos_y", sx(yout[0]), 16);
        for (int k = 0; k < 9; k++) stim_a[k] = -255;
        run_cell(0);
        check("t4_neg_x", sx(xout[0]), -131072);
        check("t4_neg_y", sx(yout[0]), -16);

        // Reset mid-run (during AY): immediate return to reset state, no step_done.
        clear_stim();
        stim_i = 16;
        stim_x0 = 100;
        @(negedge clk);
        I  = W'(stim_i);
        X0 = XW'(stim_x0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 64'(busy[0]), 0);
        check("t5_x", sx(xout[0]), 0);
        check("t5_y", sx(yout[0]), 0);
        check("t5_iter", 64'(iter_cnt[0]), 0);
        check("t5_fin", 64'(fin_flag[0]), 0);
        check("t5_step_done", 64'(step_done[0]), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_idle_after", 64'(busy[0]), 0);

        // Convergence scenario.
        clear_stim();
        stim_i = 16;
        run_cell(1);
        check("t6_x", sx(xout[1]), 15);
`ifdef CNN_CONV_DETECT_EN
        check("t6_iter", 64'(iter_cnt[1]), 5);
        check("t6_cflag", 64'(counter_flag[1]), 0);
`else
        check("t6_iter", 64'(iter_cnt[1]), 64);
        check("t6_cflag", 64'(counter_flag[1]), 1);
`endif

        // Randomized runs on both cells, moderate and full-scale operands.
        for (int r = 0; r < 12; r++) begin
            fill_random((r / 2) % 2);
            run_cell(r % 2);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
